// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: FSM states, J-type target
// field positions and the default reset vector.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam int JIDX_MSB      = 25;
    localparam int PC_REGION_MSB = 31;
    localparam int PC_REGION_LSB = 28;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch unit: resolves jr > j > branch > sequential
// and flags a jr to a non-word-aligned target.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] simm,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    output logic [31:0] next_pc,
    output logic        misaligned_hit
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [5:0]  unused_opcode;

    // The opcode bits never contribute to a target; they are only decoded upstream.
    assign unused_opcode = instr[31:26];

    assign jump_target   = {pc_plus4[PC_REGION_MSB:PC_REGION_LSB], instr[JIDX_MSB:0], 2'b00};
    assign branch_target = pc_plus4 + (simm << 2);

    always_comb begin
        next_pc        = pc_plus4;
        misaligned_hit = 1'b0;
        if (jump_reg) begin
            next_pc        = jr_target;
            misaligned_hit = (jr_target[1:0] != 2'b00);
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM: fetches over a req/ack handshake,
// holds the instruction for decode and advances the PC from pc_next_sel.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic [31:0]       simm,
    input  logic [31:0]       jr_target,
    output logic              misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misaligned_q, misaligned_d;

    logic [31:0]  next_pc;
    logic         misaligned_hit;

    assign pc_plus4 = pc_q + 32'd4;

    pc_next_sel u_pc_next_sel (
        .pc_plus4       (pc_plus4),
        .instr          (instr_q),
        .simm           (simm),
        .jr_target      (jr_target),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .jump_reg       (jump_reg),
        .next_pc        (next_pc),
        .misaligned_hit (misaligned_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            misaligned_q <= misaligned_d;
        end
    end

    // A bad jr parks the core in HALT with the faulting PC still visible.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (misaligned_hit) begin
                        misaligned_d = 1'b1;
                        state_d      = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit; a second instance with a
// wrapping reset vector shares the stimulus.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] simm = 32'h0;
    logic [31:0] jr_target = 32'h0;

    logic        imem_req, instr_valid, misaligned;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic        w_imem_req, w_instr_valid, w_misaligned;
    logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
        .simm(simm), .jr_target(jr_target), .misaligned(misaligned)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(32)) dut_w (
        .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w_instr),
        .instr_valid(w_instr_valid), .pc(w_pc), .pc_plus4(w_pc_plus4), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
        .simm(simm), .jr_target(jr_target), .misaligned(w_misaligned)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic stl,
                                 input logic br, input logic j, input logic jr,
                                 input logic [31:0] simm_v, input logic [31:0] jrt_v);
        imem_ack     = ack;
        imem_rdata   = rdata;
        stall        = stl;
        branch_taken = br;
        jump         = j;
        jump_reg     = jr;
        simm         = simm_v;
        jr_target    = jrt_v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_misaligned", {31'b0, misaligned}, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Redirect inputs carry a misaligned jr while outside EXEC; they must be ignored.
    task automatic fetchOne(input logic [31:0] addr_exp, input logic [31:0] rdata, input int waits);
        exp_t e;
        for (int i = 0; i < waits; i++) begin
            checkOutput("fetch_wait_req", {31'b0, imem_req}, 32'h1);
            checkOutput("fetch_wait_addr", imem_addr, addr_exp);
            applyStimulus(1'b0, 32'hBAD0_BAD0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h402);
        end
        checkOutput("fetch_req", {31'b0, imem_req}, 32'h1);
        checkOutput("fetch_addr", imem_addr, addr_exp);
        checkOutput("fetch_valid", {31'b0, instr_valid}, 32'h0);
        e.pc    = addr_exp;
        e.instr = rdata;
        sb_q.push_back(e);
        applyStimulus(1'b1, rdata, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h402);
    endtask

    task automatic execOne(input int stalls, input logic br, input logic j, input logic jr,
                           input logic [31:0] simm_v, input logic [31:0] jrt_v);
        exp_t e;
        checkOutput("exec_valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("exec_req", {31'b0, imem_req}, 32'h0);
        if (sb_q.size() == 0) begin
            checkOutput("sb_empty", 32'h0, 32'h1);
            e.pc    = 32'hX;
            e.instr = 32'hX;
        end else begin
            e = sb_q.pop_front();
        end
        checkOutput("exec_instr", instr, e.instr);
        checkOutput("exec_pc", pc, e.pc);
        for (int i = 0; i < stalls; i++) begin
            applyStimulus(1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1, 1'b1, 32'h7, 32'h402);
            checkOutput("stall_valid", {31'b0, instr_valid}, 32'h1);
            checkOutput("stall_pc", pc, e.pc);
            checkOutput("stall_instr", instr, e.instr);
            checkOutput("stall_misaligned", {31'b0, misaligned}, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, br, j, jr, simm_v, jrt_v);
    endtask

    initial begin
        $display("[TB] starting pc_fetch_unit bench");
        doReset();

        // Sequential fetch; the wrap instance starts at 0xFFFFFFFC and rolls to 0.
        checkOutput("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_plus4", w_pc_plus4, 32'h0);
        fetchOne(32'h0, 32'h1111_0000, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("wrap_addr1", w_imem_addr, 32'h0);
        checkOutput("wrap_req1", {31'b0, w_imem_req}, 32'h1);
        fetchOne(32'h4, 32'h1111_0004, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchOne(32'h8, 32'h1111_0008, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Wait states and stall.
        doReset();
        fetchOne(32'h0, 32'h2222_0000, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchOne(32'h4, 32'h2222_0004, 3);
        execOne(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchOne(32'h8, 32'h2222_0008, 1);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchOne(32'hC, 32'h2222_000C, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Branches backward and forward from pc 0x10.
        fetchOne(32'h10, 32'h1000_FFFE, 0);
        execOne(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0);
        fetchOne(32'hC, 32'h3333_000C, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchOne(32'h10, 32'h1000_0003, 0);
        execOne(0, 1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h0);

        // Jump priority, then jr over jump and branch.
        fetchOne(32'h20, 32'h0000_0008, 0);
        execOne(0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h3000_0000);
        fetchOne(32'h3000_0000, 32'h0800_0040, 0);
        execOne(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        fetchOne(32'h3000_0100, 32'h0800_0040, 0);
        execOne(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h400);

        // Misaligned jr halts with the PC frozen.
        fetchOne(32'h400, 32'h0000_0009, 0);
        execOne(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h402);
        checkOutput("halt_misaligned", {31'b0, misaligned}, 32'h1);
        checkOutput("halt_req", {31'b0, imem_req}, 32'h0);
        checkOutput("halt_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("halt_pc", pc, 32'h400);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("halt_hold_req", {31'b0, imem_req}, 32'h0);
        checkOutput("halt_hold_pc", pc, 32'h400);
        checkOutput("halt_hold_instr", instr, 32'h0000_0009);
        checkOutput("halt_hold_misaligned", {31'b0, misaligned}, 32'h1);
        doReset();
        fetchOne(32'h0, 32'h4444_0000, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset while a fetch waits, with a late ack just after.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("midfetch_req", {31'b0, imem_req}, 32'h1);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("midfetch_req_drop", {31'b0, imem_req}, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("late_ack_instr", instr, 32'h0);
        checkOutput("late_ack_valid", {31'b0, instr_valid}, 32'h0);
        imem_ack = 1'b0;
        fetchOne(32'h0, 32'h5555_0000, 0);
        execOne(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("after_restart_addr", imem_addr, 32'h4);

        checkOutput("sb_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the MIPS core.
- Holds the PC and fetches each instruction from instruction memory through a req/ack handshake.
- Presents each instruction to decode, where imm[15:0] goes to sign_ext. It then takes back the sign-extended immediate and the branch, jump and jr decisions to compute the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, PC and address width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory response valid; may arrive in the same cycle as req or any later cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr  out  32  latched instruction to decode.
- instr_valid  out  1  instr is valid and executing this cycle.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, combinational.
- stall  in  1  hold the current instruction; only meaningful while instr_valid=1.
- branch_taken  in  1  conditional branch resolved taken.
- jump  in  1  J/JAL.
- jump_reg  in  1  JR/JALR.
- simm  in  32  sign-extended immediate from sign_ext.
- jr_target  in  32  register value for jr.
- misaligned  out  1  sticky error flag: jr target was not word-aligned.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misaligned=0.
- States:
  - IDLE: outputs idle; go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack=1: instr<=imem_rdata, go to EXEC.
    - Otherwise stay in FETCH; pc and req are held stable.
  - EXEC: instr_valid=1, imem_req=0.
    - If stall=1: stay in EXEC; instr and pc are unchanged; redirect inputs are ignored.
    - Otherwise: pc<=next_pc, go to FETCH.
  - HALT: entered on a misaligned jr; imem_req=0, instr_valid=0; left only via rst.
- Throughput: minimum 2 cycles per instruction (zero-wait ack); each wait cycle adds 1.
- next_pc priority, highest first:
  - jump_reg: jr_target.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch_taken: pc_plus4 + (simm<<2).
  - default: pc_plus4.
- Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=0, and backward branches wrap silently.
- Simultaneous redirect inputs are resolved by the priority above and are not errors.
- Misaligned jr: jump_reg=1 with jr_target[1:0]!=0 in EXEC with stall=0:
  - misaligned<=1, pc is unchanged, go to HALT.
  - A lower-priority jump or branch in the same cycle is not taken.
- Redirect inputs are sampled only in EXEC with stall=0; they are don't-care in all other states.
- imem_ack outside FETCH is ignored; a late ack after reset must not corrupt instr.
- Reset mid-fetch: imem_req drops in the cycle after rst is sampled; the fetch restarts at RESET_PC.
- rst has priority over every other input, including stall.

Decomposition:
- Shared package mips_pkg:
  - state enum (IDLE, FETCH, EXEC, HALT).
  - J-target field constants (JIDX_MSB=25, PC_REGION_MSB=31, PC_REGION_LSB=28).
  - Default RESET_PC.
- One combinational sub-module, pc_next_sel. It takes pc_plus4, instr, simm, jr_target and the three redirect flags, and returns next_pc and misaligned_hit.
- The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Sequential fetch: reset, ack same cycle, no redirects → imem_addr sequence 0x0,0x4,0x8; instr_valid pulses every 2nd cycle; instr matches imem_rdata each time.
- Wait states and stall:
  - ack delayed 3 cycles → req and addr held at 0x4 for 4 cycles.
  - stall=1 for 2 EXEC cycles → instr_valid held 3 cycles; pc stays 0x4.
- Branch: pc=0x10, branch_taken=1, simm=32'hFFFF_FFFE → next fetch 0x0C; simm=32'h0000_0003 → next fetch 0x20.
- Jump priority: pc=0x3000_0000, instr[25:0]=26'h000_0040, jump=1 and branch_taken=1 → next pc 0x3000_0100. Adding jump_reg=1 with jr_target=0x400 → next pc 0x400.
- Misaligned jr: jr_target=0x402 → misaligned=1, imem_req stays 0, pc unchanged. After rst, misaligned=0 and fetch resumes at RESET_PC.
- Wrap and reset mid-fetch:
  - RESET_PC=32'hFFFF_FFFC, sequential → second fetch at 0x0.
  - rst asserted while FETCH waits on ack, with a late ack one cycle later → instr remains 0; the next fetch is at RESET_PC.
